// File: rtl/cotm32_pkg.sv
// cotm32 shared types and constants.
// Fetch state encoding and the canonical NOP used by the IF/ID bubble.
package cotm32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus.
// master = fetch unit, slave = instruction memory.
interface fetch_unit_if;
  import cotm32_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            ready;
  logic            rvalid;
  logic [XLEN-1:0] rdata;

  modport master (
    output req, addr,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  req, addr,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry {pc,inst} buffer for a fetch response landing during a stall.
// Clear has priority over write, write over read.
module fetch_hold_buf
  import cotm32_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            wr,
  input  logic            rd,
  input  logic            clr,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_inst,
  output logic            full,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] inst
);

  logic            full_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      full_q <= 1'b0;
      pc_q   <= '0;
      inst_q <= NOP_INST;
    end else begin
      if (clr)     full_q <= 1'b0;
      else if (wr) full_q <= 1'b1;
      else if (rd) full_q <= 1'b0;
      if (wr && !clr) begin
        pc_q   <= wr_pc;
        inst_q <= wr_inst;
      end
    end
  end

  assign full = full_q;
  assign pc   = pc_q;
  assign inst = inst_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage and IF/ID register, single outstanding imem fetch.
// Define FETCH_PERF_EN to add fetch/drop performance counters.
module fetch_unit
  import cotm32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_stall_ifid,
  input  logic            i_flush_ifid,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  fetch_unit_if.master    imem,
  output logic [XLEN-1:0] o_id_pc,
  output logic [XLEN-1:0] o_id_inst,
  output logic            o_id_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     o_perf_fetch_cnt,
  output logic [31:0]     o_perf_drop_cnt
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic [XLEN-1:0] id_pc_q;
  logic [XLEN-1:0] id_inst_q;
  logic            id_valid_q;

  logic            hold_full;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] hold_inst;

  logic req;
  logic accept;
  logic id_free;
  logic resp_keep;
  logic resp_drop;
  logic drain;
  logic hold_wr;
  logic hold_rd;

  assign accept  = req && imem.ready;
  assign id_free = !i_stall_ifid || !id_valid_q;

  assign resp_keep = imem.rvalid && (state_q == FETCH_WAIT)
                  && !i_redirect;
  assign resp_drop = imem.rvalid
                  && ((state_q == FETCH_DROP)
                   || ((state_q == FETCH_WAIT) && i_redirect));

  // A redirect empties the buffer, so nothing drains that cycle.
  assign drain   = hold_full && id_free && !i_redirect;
  assign hold_rd = drain && !i_flush_ifid;
  assign hold_wr = resp_keep && !id_free;

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (1'b1)
      state_q == FETCH_IDLE: begin
        req = i_rst_n && !hold_full && !i_redirect;
        if (req && imem.ready) state_d = FETCH_WAIT;
      end
      state_q == FETCH_WAIT: begin
        if (imem.rvalid)     state_d = FETCH_IDLE;
        else if (i_redirect) state_d = FETCH_DROP;
      end
      state_q == FETCH_DROP: begin
        if (imem.rvalid) state_d = FETCH_IDLE;
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= FETCH_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (i_redirect) begin
        pc_q <= {i_redirect_pc[XLEN-1:2], 2'b00};
      end else if (accept) begin
        pc_q     <= pc_q + 32'd4;
        req_pc_q <= pc_q;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_inst_q  <= NOP_INST;
    end else if (i_flush_ifid) begin
      id_valid_q <= 1'b0;
      id_inst_q  <= NOP_INST;
    end else if (drain) begin
      id_valid_q <= 1'b1;
      id_pc_q    <= hold_pc;
      id_inst_q  <= hold_inst;
    end else if (resp_keep && id_free) begin
      id_valid_q <= 1'b1;
      id_pc_q    <= req_pc_q;
      id_inst_q  <= imem.rdata;
    end
  end

  fetch_hold_buf u_hold (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wr      (hold_wr),
    .rd      (hold_rd),
    .clr     (i_redirect),
    .wr_pc   (req_pc_q),
    .wr_inst (imem.rdata),
    .full    (hold_full),
    .pc      (hold_pc),
    .inst    (hold_inst)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] drop_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      fetch_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (resp_keep) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (resp_drop) drop_cnt_q  <= drop_cnt_q + 32'd1;
    end
  end

  assign o_perf_fetch_cnt = fetch_cnt_q;
  assign o_perf_drop_cnt  = drop_cnt_q;
`endif

`ifndef SYNTHESIS
  a_no_orphan_rvalid: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    !(imem.rvalid && state_q == FETCH_IDLE)
  );
`endif

  assign imem.req   = req;
  assign imem.addr  = pc_q;
  assign o_id_pc    = id_pc_q;
  assign o_id_inst  = id_inst_q;
  assign o_id_valid = id_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table,
// then a randomised stream checked against an in-order scoreboard.
module tb_fetch_unit;
  import cotm32_pkg::*;

  localparam logic [31:0] D = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redir;
  logic [31:0] redir_pc;
  logic [31:0] id_pc, id_inst;
  logic        id_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_drop;
`endif

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_stall_ifid  (stall),
    .i_flush_ifid  (flush),
    .i_redirect    (redir),
    .i_redirect_pc (redir_pc),
    .imem          (imem.master),
    .o_id_pc       (id_pc),
    .o_id_inst     (id_inst),
    .o_id_valid    (id_valid)
`ifdef FETCH_PERF_EN
    ,
    .o_perf_fetch_cnt (perf_fetch),
    .o_perf_drop_cnt  (perf_drop)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return D + a;
  endfunction

  typedef struct {
    logic        stall, flush, redir;
    logic [31:0] rpc;
    logic        ready, rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(
    input logic st, fl, rd, input logic [31:0] rpc,
    input logic rdy, rv, input logic [31:0] rdat,
    input logic er, input logic [31:0] ea,
    input logic ev, input logic [31:0] ep, ei);
    vec_t v;
    v.stall = st; v.flush = fl; v.redir = rd; v.rpc = rpc;
    v.ready = rdy; v.rvalid = rv; v.rdata = rdat;
    v.e_req = er; v.e_addr = ea;
    v.e_valid = ev; v.e_pc = ep; v.e_inst = ei;
    return v;
  endfunction

  typedef struct { logic [31:0] pc, inst; } exp_t;
  exp_t sb[$];

  task automatic drive_idle();
    stall = 0; flush = 0; redir = 0; redir_pc = '0;
    imem.ready = 0; imem.rvalid = 0; imem.rdata = '0;
  endtask

  initial begin
    logic [31:0] last_pc;
    logic [31:0] cur_addr;
    logic        in_flight;
    int          wait_cnt;
    int          guard;
    exp_t        e;

    // st fl rd rpc  rdy rv rdata | req addr | valid pc inst
    vt.push_back(mk(0,0,0,0,      1,0,0,        1,32'h0,  0,0,NOP_INST));
    vt.push_back(mk(0,0,0,0,      0,1,D,        0,32'h4,  0,0,NOP_INST));
    vt.push_back(mk(0,0,0,0,      1,0,0,        1,32'h4,  1,0,D));
    vt.push_back(mk(1,0,0,0,      0,1,D+4,      0,32'h8,  1,0,D));
    vt.push_back(mk(1,0,0,0,      1,0,0,        0,32'h8,  1,0,D));
    vt.push_back(mk(0,0,0,0,      1,0,0,        0,32'h8,  1,0,D));
    vt.push_back(mk(0,0,0,0,      1,0,0,        1,32'h8,  1,4,D+4));
    vt.push_back(mk(0,0,1,32'h103,1,0,0,        0,32'hC,  1,4,D+4));
    vt.push_back(mk(0,1,0,0,      1,0,0,        0,32'h100,1,4,D+4));
    vt.push_back(mk(0,0,0,0,      0,1,D+8,      0,32'h100,0,4,NOP_INST));
    vt.push_back(mk(0,0,0,0,      0,0,0,        1,32'h100,0,4,NOP_INST));
    vt.push_back(mk(0,0,0,0,      1,0,0,        1,32'h100,0,4,NOP_INST));
    vt.push_back(mk(0,0,1,32'h200,1,1,D+32'h100,0,32'h104,0,4,NOP_INST));
    vt.push_back(mk(0,0,0,0,      0,0,0,        1,32'h200,0,4,NOP_INST));
    vt.push_back(mk(0,0,0,0,      1,0,0,        1,32'h200,0,4,NOP_INST));
    vt.push_back(mk(0,0,0,0,      0,1,D+32'h200,0,32'h204,0,4,NOP_INST));
    vt.push_back(mk(1,1,0,0,      0,0,0,        1,32'h204,1,32'h200,D+32'h200));
    vt.push_back(mk(0,0,1,32'hFFFF_FFFF,0,0,0,  0,32'h204,0,32'h200,NOP_INST));
    vt.push_back(mk(0,0,0,0,      1,0,0,        1,32'hFFFF_FFFC,0,32'h200,NOP_INST));
    vt.push_back(mk(0,0,0,0,      0,1,32'h11,   0,32'h0,  0,32'h200,NOP_INST));
    vt.push_back(mk(0,0,0,0,      0,0,0,        1,32'h0,  1,32'hFFFF_FFFC,32'h11));

    drive_idle();
    rst_n = 0;
    imem.ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   {31'b0, imem.req}, 32'd0);
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_pc",    id_pc, 32'd0);
    chk("rst_inst",  id_inst, NOP_INST);
    @(posedge clk);
    #1;
    rst_n = 1;

    foreach (vt[i]) begin
      stall = vt[i].stall; flush = vt[i].flush;
      redir = vt[i].redir; redir_pc = vt[i].rpc;
      imem.ready = vt[i].ready; imem.rvalid = vt[i].rvalid;
      imem.rdata = vt[i].rdata;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), {31'b0, imem.req},
          {31'b0, vt[i].e_req});
      chk($sformatf("v%0d_addr", i), imem.addr, vt[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, id_valid},
          {31'b0, vt[i].e_valid});
      chk($sformatf("v%0d_pc", i), id_pc, vt[i].e_pc);
      chk($sformatf("v%0d_inst", i), id_inst, vt[i].e_inst);
      @(posedge clk);
      #1;
    end

`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch, 32'd4);
    chk("perf_drop",  perf_drop,  32'd2);
`endif

    // Randomised stream: random ready, response delay and stalls.
    drive_idle();
    last_pc   = id_pc;
    in_flight = 0;
    wait_cnt  = 0;
    for (int c = 0; c < 600; c++) begin
      imem.rvalid = 0;
      if (in_flight) begin
        if (wait_cnt == 0) begin
          imem.rvalid = 1;
          imem.rdata  = mem_word(cur_addr);
          in_flight   = 0;
        end else begin
          wait_cnt--;
        end
      end
      imem.ready = ($urandom_range(0, 3) != 0);
      stall      = (c < 560) && ($urandom_range(0, 2) == 0);
      @(negedge clk);
      if (id_valid && id_pc !== last_pc) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_pc", id_pc, 32'hxxxx_xxxx);
        end else begin
          e = sb.pop_front();
          chk("sb_pc", id_pc, e.pc);
          chk("sb_inst", id_inst, e.inst);
        end
        last_pc = id_pc;
      end
      if (imem.req && imem.ready) begin
        cur_addr  = imem.addr;
        in_flight = 1;
        wait_cnt  = $urandom_range(0, 2);
        e.pc      = imem.addr;
        e.inst    = mem_word(imem.addr);
        sb.push_back(e);
      end
      @(posedge clk);
      #1;
    end

    // Stop issuing, let the last fetch retire.
    imem.ready = 0;
    stall      = 0;
    guard      = 0;
    while ((sb.size() > 1 || in_flight) && guard < 50) begin
      imem.rvalid = 0;
      if (in_flight) begin
        imem.rvalid = 1;
        imem.rdata  = mem_word(cur_addr);
        in_flight   = 0;
      end
      @(negedge clk);
      if (id_valid && id_pc !== last_pc && sb.size() > 0) begin
        e = sb.pop_front();
        chk("drain_pc", id_pc, e.pc);
        chk("drain_inst", id_inst, e.inst);
        last_pc = id_pc;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    imem.rvalid = 0;
    repeat (3) begin
      @(negedge clk);
      if (id_valid && id_pc !== last_pc && sb.size() > 0) begin
        e = sb.pop_front();
        chk("tail_pc", id_pc, e.pc);
        chk("tail_inst", id_inst, e.inst);
        last_pc = id_pc;
      end
    end
    chk("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
